// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the iterative mul/div unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MULHSU counts as signed: its src1 is the signed operand.
  function automatic logic is_signed_op(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes; the load edge already
// performs the first iteration so N iterations take N edges including the load.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  quot_q, rem_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;

  logic [XLEN-1:0] rem_src, quot_src, dsr_src;
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] rem_d, quot_d;

  // One iteration; on load it starts from a zero partial remainder.
  always_comb begin
    rem_src  = load_i ? '0 : rem_q;
    quot_src = load_i ? dividend_i : quot_q;
    dsr_src  = load_i ? divisor_i : dsr_q;
    shifted  = {rem_src, quot_src[XLEN-1]};
    diff     = shifted - {1'b0, dsr_src};
    fits     = (shifted >= {1'b0, dsr_src});
    rem_d    = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_d   = {quot_src[XLEN-2:0], fits};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= divisor_i;
      cnt_q  <= word_i ? CNT_W'(30) : CNT_W'(XLEN - 2);
      last_q <= 1'b0;
    end else if (step_i) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q - CNT_W'(1);
      last_q <= (cnt_q == CNT_W'(1));
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign last_o = last_q;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Multi-cycle RV64M/RV32M multiply/divide unit with valid/ready handshake,
// result tag, flush, and one operation in flight.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_is_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned   CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = ~(XLEN'(32'h7FFF_FFFF));

  function automatic logic [XLEN-1:0] word_fin(input logic w, input logic [XLEN-1:0] x);
    return w ? XLEN'($signed(x[31:0])) : x;
  endfunction

  muldiv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  muldiv_op_e       op_q;
  logic             word_q, qneg_q, rneg_q, rem_op_q;
  logic [XLEN-1:0]  src1_q, src2_q;
  logic [TAG_W-1:0] tag_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             accept, word_in, sgn_in, a_neg, b_neg, dvz, ovf, special;
  logic             div_load, div_step, div_last;
  logic [XLEN-1:0]  opa, opb, abs_a, abs_b, dvd, sp_res;
  logic [XLEN-1:0]  div_quot, div_rem, q_fix, r_fix, fix_res;

  muldiv_op_e        mul_op;
  logic              mul_word, sa, sb;
  logic [XLEN-1:0]   mul_a, mul_b, mul_res;
  logic [2*XLEN-1:0] mul_a_w, mul_b_w, prod;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign busy     = (state_q != ST_IDLE);

  // Divide operand prep: op-width extension, sign split, special-case detect.
  always_comb begin
    word_in = (XLEN == 64) && in_is_word;
    sgn_in  = is_signed_op(in_op);
    opa     = in_src1;
    opb     = in_src2;
    if (word_in) begin
      opa = sgn_in ? XLEN'($signed(in_src1[31:0])) : XLEN'(in_src1[31:0]);
      opb = sgn_in ? XLEN'($signed(in_src2[31:0])) : XLEN'(in_src2[31:0]);
    end
    a_neg   = sgn_in & opa[XLEN-1];
    b_neg   = sgn_in & opb[XLEN-1];
    abs_a   = a_neg ? -opa : opa;
    abs_b   = b_neg ? -opb : opb;
    dvd     = word_in ? (abs_a << (XLEN - 32)) : abs_a;
    dvz     = (opb == '0);
    ovf     = sgn_in && (opb == '1) && (opa == (word_in ? MIN_W : MIN_X));
    special = is_div_op(in_op) && (dvz || ovf);
    if (is_rem_op(in_op)) sp_res = dvz ? opa : '0;
    else                  sp_res = dvz ? '1 : opa;
    sp_res  = word_fin(word_in, sp_res);
  end

  assign div_load = accept & is_div_op(in_op) & ~special;
  assign div_step = (state_q == ST_DIV);

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (div_load),
    .step_i     (div_step),
    .word_i     (word_in),
    .dividend_i (dvd),
    .divisor_i  (abs_b),
    .quot_o     (div_quot),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  // Sign correction of the magnitude result.
  always_comb begin
    q_fix   = qneg_q ? -div_quot : div_quot;
    r_fix   = rneg_q ? -div_rem : div_rem;
    fix_res = word_fin(word_q, rem_op_q ? r_fix : q_fix);
  end

  // Single-cycle product; MUL_LAT == 1 multiplies the live inputs instead of latched ones.
  always_comb begin
    mul_op   = (MUL_LAT == 1) ? muldiv_op_e'(in_op) : op_q;
    mul_word = (MUL_LAT == 1) ? word_in : word_q;
    mul_a    = (MUL_LAT == 1) ? in_src1 : src1_q;
    mul_b    = (MUL_LAT == 1) ? in_src2 : src2_q;
    sa       = (mul_op == OP_MULH) || (mul_op == OP_MULHSU);
    sb       = (mul_op == OP_MULH);
    mul_a_w  = {{XLEN{sa & mul_a[XLEN-1]}}, mul_a};
    mul_b_w  = {{XLEN{sb & mul_b[XLEN-1]}}, mul_b};
    prod     = mul_a_w * mul_b_w;
    mul_res  = (mul_op == OP_MUL) ? word_fin(mul_word, prod[XLEN-1:0]) : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_MUL;
      word_q       <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      rem_op_q     <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      op_q     <= muldiv_op_e'(in_op);
      word_q   <= word_in;
      src1_q   <= in_src1;
      src2_q   <= in_src2;
      tag_q    <= in_tag;
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      rem_op_q <= is_rem_op(in_op);
      if (!is_div_op(in_op)) begin
        if (MUL_LAT == 1) begin
          state_q      <= ST_DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= mul_res;
          out_tag_q    <= in_tag;
        end else begin
          state_q     <= ST_MUL;
          cnt_q       <= CNT_W'(MUL_LAT - 1);
          out_valid_q <= 1'b0;
        end
      end else if (special) begin
        state_q      <= ST_DONE;
        out_valid_q  <= 1'b1;
        out_result_q <= sp_res;
        out_tag_q    <= in_tag;
      end else begin
        state_q     <= ST_DIV;
        out_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_MUL: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= mul_res;
            out_tag_q    <= tag_q;
          end
        end
        ST_DIV: begin
          if (div_last) state_q <= ST_FIX;
        end
        ST_FIX: begin
          state_q      <= ST_DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= fix_res;
          out_tag_q    <= tag_q;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (XLEN=64, MUL_LAT=3): results, tags,
// latency, backpressure, flush and reset behaviour.
module tb_muldiv_iter_unit;
  import muldiv_pkg::*;

  logic        clock;
  logic        reset_n, flush, in_valid, in_ready, in_is_word;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2;
  logic [5:0]  in_tag;
  logic        out_valid, out_ready, busy;
  logic [63:0] out_result;
  logic [5:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;

  muldiv_iter_unit #(.XLEN(64), .TAG_W(6), .MUL_LAT(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_is_word (in_is_word),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] tag);
    int guard;
    guard      = 0;
    in_valid   = 1'b1;
    in_op      = op;
    in_is_word = w;
    in_src1    = a;
    in_src2    = b;
    in_tag     = tag;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    chk("issue_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic await_valid(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [5:0] tag,
                     input logic [63:0] exp_res, input int exp_lat);
    issue(op, w, a, b, tag);
    await_valid(name, exp_lat);
    chk({name, "_res"}, out_result, exp_res);
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    tick();
  endtask

  initial begin
    logic saw;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_is_word = 1'b0;
    in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_tag",    64'(out_tag), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    reset_n = 1'b1;
    chk("rst_ready",  64'(in_ready), 64'd1);

    // Multiplies
    run("mul",    OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 6'd5, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    run("mulhu",  OP_MULHU,  1'b0, '1, '1, 6'd6, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    run("mulhsu", OP_MULHSU, 1'b0, '1, '1, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    run("mulh",   OP_MULH,   1'b1, '1, '1, 6'd8, 64'd0, 3);
    run("mulw",   OP_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd9, 64'hFFFF_FFFF_FFFF_FFFE, 3);

    // Normal divides
    run("div",   OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd10, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem",   OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd11, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("divuw", OP_DIVU, 1'b1, 64'h0000_0001_0000_000A, 64'd3, 6'd12, 64'd3, 33);
    run("remw",  OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 6'd13, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("divu",  OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 6'd14, 64'h0FFF_FFFF_FFFF_FFFF, 65);

    // Special cases
    run("divu_z", OP_DIVU, 1'b0, 64'h1234, 64'd0, 6'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_z", OP_REMU, 1'b0, 64'h1234, 64'd0, 6'd16, 64'h1234, 1);
    run("divw_o", OP_DIV,  1'b1, 64'h0000_0000_8000_0000, '1, 6'd17, 64'hFFFF_FFFF_8000_0000, 1);
    run("rem_o",  OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 6'd18, 64'd0, 1);

    // Backpressure then back-to-back accept on the transfer edge
    out_ready = 1'b0;
    issue(OP_MUL, 1'b0, 64'd6, 64'd7, 6'd19);
    await_valid("bp", 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",  64'(out_valid), 64'd1);
      chk("bp_result", out_result, 64'd42);
      chk("bp_tag",    64'(out_tag), 64'd19);
      chk("bp_ready",  64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    issue(OP_MUL, 1'b0, 64'd3, 64'd4, 6'd20);
    await_valid("b2b", 3);
    chk("b2b_res", out_result, 64'd12);
    chk("b2b_tag", 64'(out_tag), 64'd20);
    tick();

    // Flush mid-divide
    issue(OP_DIV, 1'b0, 64'd1000, 64'd3, 6'd21);
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy",  64'(busy), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    saw = out_valid;
    repeat (70) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    chk("fl_killed", 64'(saw), 64'd0);
    run("fl_mul", OP_MUL, 1'b0, 64'd5, 64'd5, 6'd22, 64'd25, 3);

    // Flush in DONE with out_ready high drops the result
    out_ready = 1'b0;
    issue(OP_MUL, 1'b0, 64'd2, 64'd3, 6'd23);
    await_valid("fd", 3);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk("fd_valid", 64'(out_valid), 64'd0);
    chk("fd_busy",  64'(busy), 64'd0);

    // Reset mid-multiply with a request pending
    issue(OP_MUL, 1'b0, 64'd9, 64'd9, 6'd30);
    reset_n = 1'b0; in_valid = 1'b1; in_op = OP_DIV;
    in_src1 = 64'd50; in_src2 = 64'd5; in_tag = 6'd31;
    tick();
    chk("rr_valid",  64'(out_valid), 64'd0);
    chk("rr_result", out_result, 64'd0);
    chk("rr_tag",    64'(out_tag), 64'd0);
    chk("rr_busy",   64'(busy), 64'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk("rr_idle", 64'(busy), 64'd0);
    run("div100", OP_DIV, 1'b0, 64'd100, 64'd7, 6'd40, 64'd14, 65);
    run("rem100", OP_REM, 1'b0, 64'd100, 64'd7, 6'd41, 64'd2, 65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
